// File: rtl/snake_engine_grid.sv
// Grid snake game core: body shift register, growth, collisions, apple relocation, score,
// plus a registered per-cell query port for the renderer. Optional macro: WRAP_EN (toroidal grid).
module snake_engine_grid #(
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 48,
  parameter int XW       = 6,
  parameter int YW       = 6,
  parameter int MAX_LEN  = 32,
  parameter int LW       = 6,
  parameter int SCORE_W  = 8,
  parameter int START_X  = 32,
  parameter int START_Y  = 24,
  parameter int APPLE_FX = 40,
  parameter int APPLE_FY = 30
) (
  input  logic               clk,
  input  logic               rst_game,
  input  logic               start,
  input  logic               tick,
  input  logic [4:0]         direction,
  input  logic [XW-1:0]      rnd_x,
  input  logic [YW-1:0]      rnd_y,
  input  logic [XW-1:0]      q_x,
  input  logic [YW-1:0]      q_y,
  output logic [1:0]         q_type,
  output logic               q_head,
  output logic               game_over,
  output logic               ate,
  output logic [SCORE_W-1:0] score,
  output logic [LW-1:0]      length
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_OVER = 2'd2} state_e;

  // Heading codes chosen so that XOR with 2'd2 yields the opposite direction.
  localparam logic [1:0] D_UP = 2'd0, D_LEFT = 2'd1, D_DOWN = 2'd2, D_RIGHT = 2'd3;

  state_e             state_q;
  logic [1:0]         dir_q, dir_d, dir_req;
  logic               dir_ok;
  logic [XW-1:0]      seg_x_q [MAX_LEN];
  logic [YW-1:0]      seg_y_q [MAX_LEN];
  logic [LW-1:0]      len_q, len_lim;
  logic [SCORE_W-1:0] score_q;
  logic [XW-1:0]      apple_x_q, nx;
  logic [YW-1:0]      apple_y_q, ny;
  logic               over_q, ate_q, qh_q;
  logic [1:0]         qt_q, qt_d;
  logic               hit_wall, hit_self, eat, grow, rnd_bad;
  logic               q_snake, q_apple, q_border;

  function automatic logic in_grid(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (int'(x) < GRID_W) && (int'(y) < GRID_H);
  endfunction

  function automatic logic on_border(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (int'(x) == 0) || (int'(x) == GRID_W - 1) || (int'(y) == 0) || (int'(y) == GRID_H - 1);
  endfunction

  always_comb begin
    dir_req = dir_q;
    dir_ok  = 1'b1;
    case (direction)
      5'b00010: dir_req = D_UP;
      5'b00100: dir_req = D_LEFT;
      5'b01000: dir_req = D_DOWN;
      5'b10000: dir_req = D_RIGHT;
      default:  dir_ok  = 1'b0;
    endcase
    if (dir_ok && !((len_q > LW'(1)) && (dir_req == (dir_q ^ 2'd2)))) dir_d = dir_req;
    else dir_d = dir_q;
  end

  always_comb begin
    nx = seg_x_q[0];
    ny = seg_y_q[0];
`ifdef WRAP_EN
    case (dir_q)
      D_UP:    ny = (int'(seg_y_q[0]) == 0) ? YW'(GRID_H - 1) : seg_y_q[0] - YW'(1);
      D_LEFT:  nx = (int'(seg_x_q[0]) == 0) ? XW'(GRID_W - 1) : seg_x_q[0] - XW'(1);
      D_DOWN:  ny = (int'(seg_y_q[0]) == GRID_H - 1) ? YW'(0) : seg_y_q[0] + YW'(1);
      default: nx = (int'(seg_x_q[0]) == GRID_W - 1) ? XW'(0) : seg_x_q[0] + XW'(1);
    endcase
    hit_wall = 1'b0;
`else
    case (dir_q)
      D_UP:    ny = seg_y_q[0] - YW'(1);
      D_LEFT:  nx = seg_x_q[0] - XW'(1);
      D_DOWN:  ny = seg_y_q[0] + YW'(1);
      default: nx = seg_x_q[0] + XW'(1);
    endcase
    hit_wall = on_border(nx, ny) || !in_grid(nx, ny);
`endif
    eat  = (nx == apple_x_q) && (ny == apple_y_q);
    grow = eat && (len_q < LW'(MAX_LEN));
    // The tail cell vacates on a plain move, so it only blocks when the body grows.
    len_lim  = grow ? len_q : len_q - LW'(1);
    hit_self = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      hit_self = hit_self | ((LW'(i) < len_lim) && (seg_x_q[i] == nx) && (seg_y_q[i] == ny));
    end
`ifdef WRAP_EN
    rnd_bad = !in_grid(rnd_x, rnd_y) || ((rnd_x == nx) && (rnd_y == ny));
`else
    rnd_bad = !in_grid(rnd_x, rnd_y) || on_border(rnd_x, rnd_y) || ((rnd_x == nx) && (rnd_y == ny));
`endif
  end

  always_comb begin
    q_snake = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      q_snake = q_snake | ((LW'(i) < len_q) && (seg_x_q[i] == q_x) && (seg_y_q[i] == q_y));
    end
    q_apple = (apple_x_q == q_x) && (apple_y_q == q_y);
`ifdef WRAP_EN
    q_border = 1'b0;
`else
    q_border = in_grid(q_x, q_y) && on_border(q_x, q_y);
`endif
    if (q_snake) qt_d = 2'd3;
    else if (q_apple) qt_d = 2'd2;
    else if (q_border) qt_d = 2'd1;
    else qt_d = 2'd0;
  end

  // Game FSM with body, apple, score and status registers.
  always_ff @(posedge clk or negedge rst_game) begin
    if (!rst_game) begin
      state_q <= S_IDLE;
      dir_q   <= D_RIGHT;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= XW'(START_X);
        seg_y_q[i] <= YW'(START_Y);
      end
      len_q     <= LW'(1);
      score_q   <= '0;
      apple_x_q <= XW'(APPLE_FX);
      apple_y_q <= YW'(APPLE_FY);
      over_q    <= 1'b0;
      ate_q     <= 1'b0;
    end else begin
      dir_q <= dir_d;
      ate_q <= 1'b0;
      if (!start) begin
        state_q    <= S_IDLE;
        seg_x_q[0] <= XW'(START_X);
        seg_y_q[0] <= YW'(START_Y);
        len_q      <= LW'(1);
        score_q    <= '0;
        over_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_RUN;
          S_RUN: begin
            if (tick) begin
              if (hit_wall || hit_self) begin
                over_q  <= 1'b1;
                state_q <= S_OVER;
              end else begin
                for (int i = 1; i < MAX_LEN; i++) begin
                  seg_x_q[i] <= seg_x_q[i-1];
                  seg_y_q[i] <= seg_y_q[i-1];
                end
                seg_x_q[0] <= nx;
                seg_y_q[0] <= ny;
                if (eat) begin
                  if (grow) len_q <= len_q + LW'(1);
                  score_q   <= score_q + SCORE_W'(1);
                  ate_q     <= 1'b1;
                  apple_x_q <= rnd_bad ? XW'(APPLE_FX) : rnd_x;
                  apple_y_q <= rnd_bad ? YW'(APPLE_FY) : rnd_y;
                end
              end
            end
          end
          S_OVER:  state_q <= S_OVER;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Per-cell query answer for the renderer, one cycle behind q_x/q_y.
  always_ff @(posedge clk or negedge rst_game) begin
    if (!rst_game) begin
      qt_q <= 2'd0;
      qh_q <= 1'b0;
    end else begin
      qt_q <= qt_d;
      qh_q <= (seg_x_q[0] == q_x) && (seg_y_q[0] == q_y);
    end
  end

  assign q_type    = qt_q;
  assign q_head    = qh_q;
  assign game_over = over_q;
  assign ate       = ate_q;
  assign score     = score_q;
  assign length    = len_q;

endmodule

// File: tb/tb_snake_engine_grid.sv
// Directed bench for snake_engine_grid (default build): movement, eating, relocation,
// self/wall collision, reversal filtering, query priority and asynchronous reset.
module tb_snake_engine_grid;
  logic       clk = 1'b0;
  logic       rst_game, start, tick;
  logic [4:0] direction;
  logic [5:0] rnd_x, rnd_y, q_x, q_y;
  logic [1:0] q_type;
  logic       q_head, game_over, ate;
  logic [7:0] score;
  logic [5:0] length;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  snake_engine_grid dut (
    .clk(clk), .rst_game(rst_game), .start(start), .tick(tick), .direction(direction),
    .rnd_x(rnd_x), .rnd_y(rnd_y), .q_x(q_x), .q_y(q_y), .q_type(q_type), .q_head(q_head),
    .game_over(game_over), .ate(ate), .score(score), .length(length)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dir(input logic [4:0] d);
    direction = d;
    step();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic qchk(input string tag, input int x, input int y, input int et, input int eh);
    q_x = 6'(x);
    q_y = 6'(y);
    step();
    chk({tag, ".type"}, int'(q_type), et);
    chk({tag, ".head"}, int'(q_head), eh);
  endtask

  initial begin
    rst_game = 1'b0; start = 1'b0; tick = 1'b0; direction = 5'b10000;
    rnd_x = 6'd10; rnd_y = 6'd10; q_x = 6'd0; q_y = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.qtype", int'(q_type), 0);
    chk("rst.qhead", int'(q_head), 0);
    chk("rst.len", int'(length), 1);
    chk("rst.score", int'(score), 0);
    chk("rst.over", int'(game_over), 0);
    chk("rst.ate", int'(ate), 0);
    rst_game = 1'b1;
    qchk("idle.head", 32, 24, 3, 1);
    qchk("idle.apple", 40, 30, 2, 0);
    qchk("idle.border", 0, 0, 1, 0);

    // three ticks to the right from the start cell
    start = 1'b1;
    step();
    ticks(3);
    qchk("t1.head", 35, 24, 3, 1);
    qchk("t1.vacated", 32, 24, 0, 0);
    chk("t1.len", int'(length), 1);
    chk("t1.over", int'(game_over), 0);

    // eat the fallback apple at (40,30), relocate it to (45,33)
    set_dir(5'b01000);
    ticks(6);
    set_dir(5'b10000);
    ticks(4);
    rnd_x = 6'd45; rnd_y = 6'd33;
    do_tick();
    chk("eat1.ate", int'(ate), 1);
    chk("eat1.len", int'(length), 2);
    chk("eat1.score", int'(score), 1);
    step();
    chk("eat1.ate_clr", int'(ate), 0);
    qchk("eat1.apple", 45, 33, 2, 0);
    qchk("eat1.head", 40, 30, 3, 1);

    // border candidate falls back to (40,30)
    ticks(5);
    set_dir(5'b01000);
    rnd_x = 6'd0; rnd_y = 6'd5;
    ticks(3);
    chk("eat2.len", int'(length), 3);
    chk("eat2.score", int'(score), 2);
    qchk("eat2.fallback", 40, 30, 2, 0);
    qchk("eat2.body", 45, 32, 3, 0);

    // third apple: length 4, next apple at (37,31)
    set_dir(5'b00100);
    ticks(5);
    set_dir(5'b00010);
    rnd_x = 6'd37; rnd_y = 6'd31;
    ticks(3);
    chk("eat3.len", int'(length), 4);
    qchk("eat3.apple", 37, 31, 2, 0);

    // 2x2 loop: moving into the vacating tail cell is legal
    set_dir(5'b10000);
    do_tick();
    set_dir(5'b01000);
    do_tick();
    set_dir(5'b00100);
    do_tick();
    chk("tail.over", int'(game_over), 0);
    qchk("tail.head", 40, 31, 3, 1);

    // reversal and non-one-hot codes are ignored at length 4
    set_dir(5'b10000);
    do_tick();
    qchk("rev.head", 39, 31, 3, 1);
    set_dir(5'b00011);
    do_tick();
    qchk("bad.head", 38, 31, 3, 1);

    // fourth apple, then steer into segment 3 of a U
    rnd_x = 6'd20; rnd_y = 6'd20;
    do_tick();
    chk("eat4.len", int'(length), 5);
    chk("eat4.score", int'(score), 4);
    set_dir(5'b00010);
    do_tick();
    set_dir(5'b10000);
    do_tick();
    set_dir(5'b01000);
    do_tick();
    chk("self.over", int'(game_over), 1);
    qchk("self.head", 38, 30, 3, 1);
    do_tick();
    qchk("self.frozen", 38, 30, 3, 1);
    chk("self.len", int'(length), 5);

    // return to idle reloads, then run into the right border
    start = 1'b0;
    set_dir(5'b10000);
    chk("idle.over", int'(game_over), 0);
    chk("idle.len", int'(length), 1);
    chk("idle.score", int'(score), 0);
    start = 1'b1;
    step();
    ticks(30);
    qchk("wall.pre", 62, 24, 3, 1);
    chk("wall.pre_over", int'(game_over), 0);
    do_tick();
    chk("wall.over", int'(game_over), 1);
    qchk("wall.head", 62, 24, 3, 1);
    do_tick();
    qchk("wall.frozen", 62, 24, 3, 1);
    qchk("wall.cell", 63, 24, 1, 0);

    // tick together with start=0: reload wins
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    do_tick();
    tick = 1'b1; start = 1'b0;
    step();
    tick = 1'b0;
    qchk("tickidle.head", 32, 24, 3, 1);
    qchk("tickidle.old", 33, 24, 0, 0);

    // asynchronous reset in the middle of a run
    start = 1'b1;
    step();
    ticks(2);
    qchk("arst.pre", 0, 0, 1, 0);
    #2;
    rst_game = 1'b0;
    #1;
    chk("arst.qtype", int'(q_type), 0);
    chk("arst.len", int'(length), 1);
    chk("arst.over", int'(game_over), 0);
    chk("arst.ate", int'(ate), 0);
    chk("arst.score", int'(score), 0);
    #3;
    rst_game = 1'b1;
    qchk("arst.head", 32, 24, 3, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
